// File: rtl/float_int_convert.sv
// Multi-cycle converter between 32-bit two's-complement integers and IEEE-754 single floats.
// Truncating rounding; a one-bit-per-cycle shifter handles normalisation in both directions.
module float_int_convert (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] a,
    output logic [31:0] z,
    output logic [1:0]  flag,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SHIFT,
        PACK,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        mode_r;
    logic [31:0] a_r;
    logic [31:0] mag;
    logic [7:0]  exp_r;
    logic [4:0]  cnt;
    logic        sticky;

    logic [7:0]  e;
    logic [22:0] f;
    logic [31:0] abs_a;
    logic [7:0]  cnt_init;
    logic        special;
    logic [31:0] special_z;
    logic [1:0]  special_flag;

    assign e        = a_r[30:23];
    assign f        = a_r[22:0];
    assign abs_a    = a_r[31] ? (~a_r + 32'd1) : a_r;
    assign cnt_init = 8'd158 - e;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Cases resolved directly in CHECK without touching the shifter.
    always_comb begin
        special      = 1'b0;
        special_z    = 32'h0000_0000;
        special_flag = 2'b00;
        if (!mode_r) begin
            if (a_r == 32'h0000_0000) begin
                special = 1'b1;
            end
        end else begin
            if (e == 8'hFF) begin
                special = 1'b1;
                if (f != 23'd0) begin
                    special_flag = 2'b11;
                end else begin
                    special_z    = a_r[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    special_flag = 2'b10;
                end
            end else if (e < 8'd127) begin
                special      = 1'b1;
                special_flag = (a_r[30:0] != 31'd0) ? 2'b01 : 2'b00;
            end else if (a_r == 32'hCF00_0000) begin
                special   = 1'b1;
                special_z = 32'h8000_0000;
            end else if (e >= 8'd158) begin
                special      = 1'b1;
                special_z    = a_r[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                special_flag = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (special) begin
                    state_next = DONE;
                end else if (!mode_r && abs_a[31]) begin
                    state_next = PACK;
                end else begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // mag[30] becomes the new mag[31] after this cycle's left shift.
                if (!mode_r) begin
                    if (mag[30]) begin
                        state_next = PACK;
                    end
                end else if (cnt == 5'd1) begin
                    state_next = PACK;
                end
            end
            PACK:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r <= 1'b0;
            a_r    <= 32'h0000_0000;
            mag    <= 32'h0000_0000;
            exp_r  <= 8'd0;
            cnt    <= 5'd0;
            sticky <= 1'b0;
            z      <= 32'h0000_0000;
            flag   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        a_r    <= a;
                    end
                end
                CHECK: begin
                    sticky <= 1'b0;
                    if (!mode_r) begin
                        mag   <= abs_a;
                        exp_r <= 8'd158;
                    end else begin
                        mag <= {1'b1, f, 8'b0};
                        cnt <= cnt_init[4:0];
                    end
                    if (special) begin
                        z    <= special_z;
                        flag <= special_flag;
                    end
                end
                SHIFT: begin
                    if (!mode_r) begin
                        mag   <= mag << 1;
                        exp_r <= exp_r - 8'd1;
                    end else begin
                        sticky <= sticky | mag[0];
                        mag    <= mag >> 1;
                        cnt    <= cnt - 5'd1;
                    end
                end
                PACK: begin
                    if (!mode_r) begin
                        z    <= {a_r[31], exp_r, mag[30:8]};
                        flag <= (mag[7:0] != 8'd0) ? 2'b01 : 2'b00;
                    end else begin
                        z    <= a_r[31] ? (~mag + 32'd1) : mag;
                        flag <= sticky ? 2'b01 : 2'b00;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_int_convert.sv
// Scoreboard bench for float_int_convert: expectations are queued at start, compared on done.
module tb_float_int_convert;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] a;
    logic [31:0] z;
    logic [1:0]  flag;
    logic        busy;
    logic        done;

    typedef struct {
        string       tag;
        logic [31:0] z;
        logic [1:0]  flag;
        int          lat;
        int          start_edge;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;

    float_int_convert dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .a     (a),
        .z     (z),
        .flag  (flag),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference int->float with truncation; latency counts the normalising shifts.
    function automatic void modelI2f(input logic [31:0] v, output logic [31:0] rz,
                                     output logic [1:0] rf, output int lat);
        logic [31:0] m;
        int lz;
        if (v == 32'd0) begin
            rz = 32'd0; rf = 2'b00; lat = 2;
        end else begin
            m  = v[31] ? -v : v;
            lz = 0;
            while (!m[31]) begin
                m = m << 1;
                lz++;
            end
            rz  = {v[31], 8'(158 - lz), m[30:8]};
            rf  = (m[7:0] != 8'd0) ? 2'b01 : 2'b00;
            lat = 3 + lz;
        end
    endfunction

    always @(negedge clk) begin
        exp_t item;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_done", 32'd1, 32'd0);
            end else begin
                item = sb.pop_front();
                checkOutput({item.tag, "_z"}, z, item.z);
                checkOutput({item.tag, "_flag"}, {30'd0, flag}, {30'd0, item.flag});
                checkOutput({item.tag, "_lat"}, edge_cnt - item.start_edge + 1, item.lat);
            end
        end
    end

    task automatic pushExp(input string tag, input logic [31:0] ez, input logic [1:0] ef, input int lat);
        exp_t item;
        item.tag        = tag;
        item.z          = ez;
        item.flag       = ef;
        item.lat        = lat;
        item.start_edge = edge_cnt + 1;
        sb.push_back(item);
    endtask

    task automatic waitDone();
        bit seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        if (!seen) begin
            checkOutput("done_timeout", 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input string tag, input logic m, input logic [31:0] v,
                                 input logic [31:0] ez, input logic [1:0] ef, input int lat);
        mode  = m;
        a     = v;
        start = 1'b1;
        pushExp(tag, ez, ef, lat);
        @(negedge clk);
        start = 1'b0;
        mode  = ~m;
        a     = ~v;
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
        waitDone();
    endtask

    initial begin
        logic [31:0] rz;
        logic [1:0]  rf;
        int          lat;
        logic [31:0] v;
        int          sv;

        rst = 1'b1; start = 1'b0; mode = 1'b0; a = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset_z", z, 32'd0);
        checkOutput("reset_flag", {30'd0, flag}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus("i2f_one",  1'b0, 32'h0000_0001, 32'h3F80_0000, 2'b00, 34);
        applyStimulus("i2f_zero", 1'b0, 32'h0000_0000, 32'h0000_0000, 2'b00, 2);
        applyStimulus("i2f_min",  1'b0, 32'h8000_0000, 32'hCF00_0000, 2'b00, 3);
        applyStimulus("i2f_max",  1'b0, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 2'b01, 4);
        applyStimulus("f2i_pi",   1'b1, 32'hC049_0FDB, 32'hFFFF_FFFD, 2'b01, 33);
        applyStimulus("f2i_one",  1'b1, 32'h3F80_0000, 32'h0000_0001, 2'b00, 34);
        applyStimulus("f2i_pinf", 1'b1, 32'h7F80_0000, 32'h7FFF_FFFF, 2'b10, 2);
        applyStimulus("f2i_ninf", 1'b1, 32'hFF80_0000, 32'h8000_0000, 2'b10, 2);
        applyStimulus("f2i_nan",  1'b1, 32'h7FC0_0000, 32'h0000_0000, 2'b11, 2);
        applyStimulus("f2i_big",  1'b1, 32'h4F00_0000, 32'h7FFF_FFFF, 2'b10, 2);
        applyStimulus("f2i_min",  1'b1, 32'hCF00_0000, 32'h8000_0000, 2'b00, 2);
        applyStimulus("f2i_half", 1'b1, 32'h3F00_0000, 32'h0000_0000, 2'b01, 2);
        applyStimulus("f2i_e157", 1'b1, 32'h4EFF_FFFF, 32'h7FFF_FF80, 2'b00, 4);

        // A second start while busy must not disturb the running operation.
        mode = 1'b0; a = 32'h0000_0001; start = 1'b1;
        pushExp("ignored_start", 32'h3F80_0000, 2'b00, 34);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        mode = 1'b1; a = 32'h3F80_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone();
        checkOutput("ignored_hold_z", z, 32'h3F80_0000);
        checkOutput("ignored_idle", {31'd0, busy}, 32'd0);

        // Abort mid-shift: no done, outputs cleared, then a clean restart.
        mode = 1'b0; a = 32'h0000_0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_z", z, 32'd0);
        checkOutput("abort_flag", {30'd0, flag}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        applyStimulus("after_abort", 1'b0, 32'hFFFF_FFFF, 32'hBF80_0000, 2'b00, 34);

        for (int i = 0; i < 1000; i++) begin
            if (i % 2 == 0) begin
                sv = int'($urandom_range(0, 32'h01FF_FFFE)) - 32'h00FF_FFFF;
                v  = sv;
            end else begin
                v = $urandom;
            end
            modelI2f(v, rz, rf, lat);
            applyStimulus("rt_i2f", 1'b0, v, rz, rf, lat);
            if (i % 2 == 0) begin
                lat = (v == 32'd0) ? 2 : 3 + (158 - int'(rz[30:23]));
                applyStimulus("rt_f2i", 1'b1, z, v, 2'b00, lat);
            end
        end

        repeat (3) @(negedge clk);
        checkOutput("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/float_int_convert.md
# float_int_convert

Multi-cycle IEEE-754 single-precision converter between 32-bit two's-complement integers and floats. It produces operands for the float adder and consumes its results, so the same datapath flavour runs in both directions. Normalisation and denormalisation use a one-bit-per-cycle shifter FSM. Rounding is truncation toward zero, matching the adder; status is reported on a 2-bit flag.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request pulse; sampled only in IDLE.
- `mode`  in  1  0 = int→float, 1 = float→int; captured with `start`.
- `a`  in  32  operand (signed int or float bits); captured with `start`.
- `z`  out  32  result register; holds until the next completion.
- `flag`  out  2  status: 00 exact, 01 inexact (nonzero bits truncated), 10 saturated/overflow, 11 NaN input.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `z`/`flag` are valid from this cycle onward.

## Operation
- States: IDLE → CHECK → (SHIFT)* → PACK → DONE → IDLE. Special cases go CHECK → DONE.
- IDLE: on `start`=1, capture `mode`, `a` and go to CHECK. `start` in any other state is ignored.
- int→float, CHECK:
  - `sign`=a[31]; `mag`=|a| as 32-bit unsigned (0x80000000 stays 0x80000000); `exp`=158.
  - a==0 → z=0x00000000, flag 00, go DONE.
  - mag[31]=1 → PACK; else SHIFT.
- int→float, SHIFT: mag<<=1, exp-=1 per cycle; leave for PACK when the new mag[31]=1.
- int→float, PACK: z={sign, exp[7:0], mag[30:8]}; flag=01 if mag[7:0]≠0, else 00.
- float→int, CHECK (e=a[30:23], f=a[22:0]):
  - e=255, f≠0 → z=0, flag 11.
  - e=255, f=0 → z = sign ? 0x80000000 : 0x7FFFFFFF, flag 10.
  - e<127 → z=0; flag 01 if e|f ≠ 0, else 00.
  - a==0xCF000000 → z=0x80000000, flag 00.
  - Other e≥158 → saturate as for infinity, flag 10.
  - All of the above go to DONE.
  - Otherwise (127≤e≤157): mag={1,f,8'b0}, cnt=158−e (1..31), sticky=0, go SHIFT.
- float→int, SHIFT: sticky|=mag[0]; mag>>=1; cnt-=1; go to PACK when cnt reaches 0.
- float→int, PACK: z = sign ? −mag : mag (32-bit two's complement); flag = sticky ? 01 : 00.
- DONE: `done`=1 for exactly one cycle, then IDLE. `z`/`flag` are written on the transition into DONE.
- Reset or abort: `rst` in any state forces IDLE, z=0, flag=00, busy=0, done=0. An operation interrupted by reset never asserts `done`.

## Timing
- Let cycle 0 be the edge that samples `start`.
- Special case: `done` high in cycle 2.
- Normal case: `done` high in cycle 3+k.
  - int→float: k = leading zeros of `mag` (0..31).
  - float→int: k = 158−e.
- Worst case: 34 cycles.
- Back-to-back: `start` may be raised again in the cycle after `done`, since the FSM is back in IDLE.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- `a` and `mode` may change freely while `busy`=1.

## Test plan
- int→float a=0x00000001 → z=0x3F800000, flag 00, k=31, `done` in cycle 34. a=0 → z=0x00000000, `done` in cycle 2.
- int→float a=0x80000000 → z=0xCF000000, flag 00, k=0. a=0x7FFFFFFF → z=0x4EFFFFFF, flag 01.
- float→int a=0xC0490FDB (−3.14159) → z=0xFFFFFFFD, flag 01. a=0x3F800000 → z=0x00000001, flag 00.
- float→int specials:
  - 0x7F800000 → 0x7FFFFFFF / 10.
  - 0xFF800000 → 0x80000000 / 10.
  - 0x7FC00000 → 0 / 11.
  - 0x4F000000 → 0x7FFFFFFF / 10.
  - 0xCF000000 → 0x80000000 / 00.
  - 0x3F000000 → 0 / 01.
  - Each has `done` in cycle 2.
- Pulse `start` with a different `a` while busy → ignored; the first result is unchanged. Assert `rst` mid-SHIFT → `done` never pulses, z=0, flag=00; a fresh `start` then completes normally.
- Random round-trip (int→float→int) on 1000 values: result equals the original whenever |a|<2^24 and flag=00.
